// File: rtl/bit_serial_adder.sv
// bit_serial_adder: adds two W-bit operands LSB-first through one full-adder cell and a carry flop over W cycles.
module bit_serial_adder #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         overflow
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, nxt;
    logic [W-1:0]  sa, sb, ps;
    logic [CW-1:0] cnt;
    logic          c, s, cn, last, accept;

    assign s      = sa[0] ^ sb[0] ^ c;
    assign cn     = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    assign last   = cnt == CW'(W - 1);
    assign accept = start && state != RUN;
    assign busy   = state == RUN;
    assign done   = state == DONE;

    always_comb begin
        nxt = state;
        nxt = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            ps       <= '0;
            cnt      <= '0;
            c        <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                sa  <= a;
                sb  <= b;
                c   <= cin;
                cnt <= '0;
                ps  <= '0;
            end else if (state == RUN) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                c   <= cn;
                ps  <= {s, ps[W-1:1]};
                cnt <= cnt + 1'b1;
                // c here is still the carry into the MSB, so overflow is carry-in XOR carry-out of bit W-1
                if (last) begin
                    sum      <= {s, ps[W-1:1]};
                    cout     <= cn;
                    overflow <= c ^ cn;
                end
            end
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed W=8 vectors plus randomized W=32 operands against a reference sum model.
module tb_bit_serial_adder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        st8 = 1'b0, cin8 = 1'b0, st32 = 1'b0, cin32 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic [31:0] a32 = '0, b32 = '0, sum32;
    logic        busy8, done8, cout8, ovf8, busy32, done32, cout32, ovf32;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.W(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    bit_serial_adder #(.W(32)) u32 (
        .clk(clk), .rst(rst), .start(st32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .overflow(ovf32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts one W=8 add and checks done arrives in cycle 9 with the given results.
    task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic ci,
                        input logic [7:0] es, input logic ec, input logic eo);
        int n = 0, nb = 0;
        @(negedge clk);
        a8 = x; b8 = y; cin8 = ci; st8 = 1'b1;
        @(posedge clk);
        #1 st8 = 1'b0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy8) nb++;
        end
        check({tag, " cycle"}, 64'(n), 64'd9);
        check({tag, " busycycles"}, 64'(nb), 64'd8);
        check({tag, " busy@done"}, 64'(busy8), 64'd0);
        check({tag, " sum"}, 64'(sum8), 64'(es));
        check({tag, " cout"}, 64'(cout8), 64'(ec));
        check({tag, " ovf"}, 64'(ovf8), 64'(eo));
    endtask

    initial begin
        int n, nd, d1, d2;
        logic [32:0] r;
        logic        eo;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy8), 64'd0);
        check("rst done", 64'(done8), 64'd0);
        check("rst sum", 64'({sum8, sum32}), 64'd0);
        check("rst cout/ovf", 64'({cout8, ovf8, cout32, ovf32}), 64'd0);
        rst = 1'b0;

        run8("t1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("t2b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run8("t2c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

        // operand changes and start pulses while busy must not disturb the add
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; st8 = 1'b1;
        @(posedge clk);
        #1 st8 = 1'b0;
        n = 0; nd = 0; d1 = 0;
        while (n < 14) begin
            @(negedge clk);
            n++;
            if (done8) begin nd++; d1 = n; end
            if (done8) check("t3 sum", 64'(sum8), 64'h47);
            if (done8) check("t3 cout/ovf", 64'({cout8, ovf8}), 64'd0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            st8 = (n == 3 || n == 7);
        end
        st8 = 1'b0;
        check("t3 donecount", 64'(nd), 64'd1);
        check("t3 donecycle", 64'(d1), 64'd9);
        check("t3 hold sum", 64'(sum8), 64'h47);

        // back-to-back with start held high
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; st8 = 1'b1;
        @(posedge clk);
        n = 0; d1 = 0; d2 = 0;
        while (d2 == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin a8 = 8'hF0; b8 = 8'h10; end
            check("b2b excl", 64'(busy8 & done8), 64'd0);
            if (done8 && d1 == 0) begin
                d1 = n;
                check("b2b sum1", 64'({cout8, sum8}), 64'h010);
            end else if (done8) begin
                d2 = n;
                check("b2b sum2", 64'({cout8, sum8}), 64'h100);
            end
        end
        st8 = 1'b0;
        check("b2b done1", 64'(d1), 64'd9);
        check("b2b done2", 64'(d2), 64'd18);

        // reset in cycle 4 of a RUN
        run8("t4pre", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; st8 = 1'b1;
        @(posedge clk);
        #1 st8 = 1'b0;
        repeat (4) @(negedge clk);
        check("t5 busy pre", 64'(busy8), 64'd1);
        rst = 1'b1;
        #1;
        check("t5 busy", 64'(busy8), 64'd0);
        check("t5 done", 64'(done8), 64'd0);
        check("t5 outs", 64'({sum8, cout8, ovf8}), 64'd0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) nd++;
            if (n == 5) rst = 1'b0;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("t5 nodone", 64'(nd), 64'd0);
        run8("t5post", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

        // randomized W=32 against a+b+cin
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
            if (i < 4) begin
                a32 = (i[0]) ? 32'h7FFF_FFFF : 32'h8000_0000;
                b32 = (i[1]) ? 32'hFFFF_FFFF : 32'h8000_0000;
            end
            r  = {1'b0, a32} + {1'b0, b32} + {32'd0, cin32};
            eo = (a32[31] == b32[31]) && (r[31] != a32[31]);
            st32 = 1'b1;
            @(posedge clk);
            #1 st32 = 1'b0;
            n = 0;
            while (!done32 && n < 80) begin
                @(negedge clk);
                n++;
            end
            if (n != 33) check("r32 cycle", 64'(n), 64'd33);
            check("r32 sum", 64'(sum32), 64'(r[31:0]));
            check("r32 cout", 64'(cout32), 64'(r[32]));
            check("r32 ovf", 64'(ovf32), 64'(eo));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
